// File: rtl/finv_iter_pkg.sv
// rtl/finv_iter_pkg.sv - shared types and constants for the iterative reciprocal unit
package finv_iter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_MUL_A = 3'd2,
        ST_MUL_B = 3'd3,
        ST_PACK  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

endpackage

// File: rtl/finv_seed.sv
// rtl/finv_seed.sv - combinational seed table for the reciprocal iteration
module finv_seed #(
    parameter int SEED_BITS = 8,
    parameter int FRAC_W    = 32
) (
    input  logic [SEED_BITS-1:0] idx,
    output logic [FRAC_W:0]      seed
);

    localparam int N = 1 << SEED_BITS;

    logic [FRAC_W:0] rom [N];

    // Entry i holds 1/(1+(i+0.5)/N) in Q1.FRAC_W, i.e. 2N*2^FRAC_W/(2N+2i+1),
    // evaluated at elaboration so the table is a pure constant ROM.
    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam logic [63:0]     NUM = 64'd1 << (FRAC_W + SEED_BITS + 1);
        localparam logic [63:0]     DEN = 64'(2 * N + 2 * i + 1);
        localparam logic [FRAC_W:0] VAL = (FRAC_W + 1)'(NUM / DEN);
        assign rom[i] = VAL;
    end

    assign seed = rom[idx];

endmodule

// File: rtl/finv_iter.sv
// rtl/finv_iter.sv - IEEE-754 single reciprocal by seeded Newton-Raphson iteration
module finv_iter
    import finv_iter_pkg::*;
#(
    parameter int ITERS     = 2,
    parameter int SEED_BITS = 8,
    parameter int FRAC_W    = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_dz,
    output logic        out_nv
);

    localparam int W = FRAC_W + 2;
    localparam logic [W-1:0] TWO = {2'b10, {FRAC_W{1'b0}}};

    state_e              state_q, state_d;
    logic [2:0]          iter_q, iter_d;
    logic [W-1:0]        x_q, x_d, t_q, t_d;
    logic [31:0]         out_data_q, out_data_d;
    logic                dz_q, dz_d, nv_q, nv_d;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_q;
    logic [MANT_W-1:0]   mant_q;
    logic                accept;

    logic [FRAC_W:0]     seed;
    logic [W-1:0]        m_fix, two_minus_t, mul_b, prod;

    logic [FRAC_W-1:0]   norm;
    logic [MANT_W-1:0]   frac;
    logic                guard, rbit, sticky;
    logic [MANT_W:0]     rnd;
    logic [9:0]          e_res;
    logic [MANT_W-1:0]   pack_sig;
    logic [31:0]         pack_data;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign out_dz    = dz_q;
    assign out_nv    = nv_q;
    assign accept    = in_valid && in_ready;

    finv_seed #(
        .SEED_BITS(SEED_BITS),
        .FRAC_W   (FRAC_W)
    ) u_seed (
        .idx (mant_q[MANT_W-1 -: SEED_BITS]),
        .seed(seed)
    );

    // m = 1.mant in Q2.FRAC_W; the single multiplier takes m in MUL_A and (2-t) in MUL_B
    assign m_fix       = {2'b01, mant_q, {(FRAC_W - MANT_W){1'b0}}};
    assign two_minus_t = TWO - t_q;
    assign mul_b       = (state_q == ST_MUL_B) ? two_minus_t : m_fix;
    assign prod        = W'(({{W{1'b0}}, x_q} * {{W{1'b0}}, mul_b}) >> FRAC_W);

    // Normalise x, round to nearest-even and assemble the float (specials override)
    always_comb begin
        norm     = x_q[FRAC_W] ? x_q[FRAC_W-1:0] : {x_q[FRAC_W-2:0], 1'b0};
        frac     = norm[FRAC_W-1 -: MANT_W];
        guard    = norm[FRAC_W-1-MANT_W];
        rbit     = norm[FRAC_W-2-MANT_W];
        sticky   = |norm[FRAC_W-3-MANT_W:0];
        rnd      = {1'b0, frac} + {{MANT_W{1'b0}}, guard & (rbit | sticky | frac[0])};
        if (mant_q == '0) begin
            e_res    = 10'(2 * BIAS) - {2'b00, exp_q};
            pack_sig = '0;
        end else begin
            e_res    = 10'(2 * BIAS - 1) - {2'b00, exp_q}
                       + {9'd0, x_q[FRAC_W]} + {9'd0, rnd[MANT_W]};
            pack_sig = rnd[MANT_W-1:0];
        end
        if (e_res[9] || (e_res == '0)) begin
            pack_data = {sign_q, 31'd0};
        end else begin
            pack_data = {sign_q, e_res[EXP_W-1:0], pack_sig};
        end
    end

    // Next-state, iteration datapath and result capture
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        x_d        = x_q;
        t_d        = t_q;
        out_data_d = out_data_q;
        dz_d       = dz_q;
        nv_d       = nv_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SEED;
            end
            ST_SEED: begin
                x_d     = {1'b0, seed};
                iter_d  = '0;
                state_d = ST_MUL_A;
            end
            ST_MUL_A: begin
                t_d     = prod;
                state_d = ST_MUL_B;
            end
            ST_MUL_B: begin
                x_d = prod;
                if (iter_q == 3'(ITERS - 1)) begin
                    iter_d  = '0;
                    state_d = ST_PACK;
                end else begin
                    iter_d  = iter_q + 3'd1;
                    state_d = ST_MUL_A;
                end
            end
            ST_PACK: begin
                dz_d = 1'b0;
                nv_d = 1'b0;
                if (exp_q == EXP_MAX && mant_q != '0) begin
                    out_data_d = QNAN;
                    nv_d       = 1'b1;
                end else if (exp_q == EXP_MAX) begin
                    out_data_d = {sign_q, 31'd0};
                end else if (exp_q == '0) begin
                    out_data_d = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
                    dz_d       = 1'b1;
                end else begin
                    out_data_d = pack_data;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, iteration registers and held result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            x_q        <= '0;
            t_q        <= '0;
            out_data_q <= '0;
            dz_q       <= 1'b0;
            nv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            x_q        <= x_d;
            t_q        <= t_d;
            out_data_q <= out_data_d;
            dz_q       <= dz_d;
            nv_q       <= nv_d;
        end
    end

    // Operand capture on the accepting edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
        end else if (accept) begin
            sign_q <= in_data[31];
            exp_q  <= in_data[30:23];
            mant_q <= in_data[22:0];
        end
    end

endmodule

// File: tb/tb_finv_iter.sv
// tb/tb_finv_iter.sv - scoreboard bench for finv_iter
module tb_finv_iter;

    localparam int ITERS = 2;
    localparam int LAT   = 2 * ITERS + 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_dz;
    logic        out_nv;

    finv_iter #(.ITERS(ITERS), .SEED_BITS(8), .FRAC_W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_dz   (out_dz),
        .out_nv   (out_nv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        dz;
        logic        nv;
        int          tol;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic dz, input logic nv, input int tol);
        exp_t e;
        e.data = d; e.dz = dz; e.nv = nv; e.tol = tol; e.acc = 0;
        return e;
    endfunction

    // Correctly rounded reciprocal from exact integer division
    function automatic exp_t model(input logic [31:0] a);
        exp_t         r;
        logic         s;
        int           e, ex;
        logic [22:0]  mt;
        logic [127:0] num, den, q, rem;
        logic [24:0]  sig;
        s = a[31]; e = int'(a[30:23]); mt = a[22:0];
        r = mk(32'h0, 1'b0, 1'b0, 0);
        if (e == 255 && mt != 0) begin
            r.data = 32'h7FC00000; r.nv = 1'b1;
        end else if (e == 255) begin
            r.data = {s, 31'd0};
        end else if (e == 0) begin
            r.data = {s, 8'hFF, 23'd0}; r.dz = 1'b1;
        end else begin
            if (mt == 0) begin
                ex = 254 - e; sig = '0;
            end else begin
                den = {104'd1, mt};
                num = 128'd1 << 71;
                q   = num / den;
                rem = num % den;
                sig = {1'b0, q[47:24]};
                if (q[23] && ((q[22:0] != 0) || (rem != 0) || sig[0])) sig = sig + 25'd1;
                ex = 253 - e;
                if (sig[24]) begin sig = 25'h0800000; ex = ex + 1; end
                r.tol = 1;
            end
            if (ex <= 0) r.data = {s, 31'd0};
            else         r.data = {s, 8'(ex), sig[22:0]};
        end
        return r;
    endfunction

    // Monitor: latency on each rising out_valid, result compare on each handshake
    initial begin
        exp_t cur;
        bit   prev_valid = 1'b0;
        int   diff;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_valid: got out_valid=1 expected no pending result");
                end else begin
                    check("latency", 32'(cyc - sb[0].acc), 32'(LAT));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                cur = sb.pop_front();
                if (cur.tol != 0) begin
                    diff = int'(out_data[30:0]) - int'(cur.data[30:0]);
                    checks++;
                    if (out_data[31] !== cur.data[31] || diff > 1 || diff < -1) begin
                        errors++;
                        $display("FAIL data_ulp: got %08h expected %08h (+/-1 ulp)", out_data, cur.data);
                    end
                end else begin
                    check("data", out_data, cur.data);
                end
                check("dz", 32'(out_dz), 32'(cur.dz));
                check("nv", 32'(out_nv), 32'(cur.nv));
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [31:0] d, input exp_t e, input bit track);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 500 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.acc = cyc;
        if (track) sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] sp [6];
        int          low_seen;
        sp = '{32'h00000000, 32'h80000001, 32'h7F800000, 32'hFF800000, 32'h7FFFFFFF, 32'h807FFFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", {30'd0, out_dz, out_nv}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send(32'h40000000, mk(32'h3F000000, 1'b0, 1'b0, 0), 1'b1);
        send(32'h40400000, mk(32'h3EAAAAAB, 1'b0, 1'b0, 1), 1'b1);
        send(32'hC0400000, mk(32'hBEAAAAAB, 1'b0, 1'b0, 1), 1'b1);
        send(32'h00000000, mk(32'h7F800000, 1'b1, 1'b0, 0), 1'b1);
        send(32'h80000001, mk(32'hFF800000, 1'b1, 1'b0, 0), 1'b1);
        send(32'h7F800000, mk(32'h00000000, 1'b0, 1'b0, 0), 1'b1);
        send(32'h7FC00001, mk(32'h7FC00000, 1'b0, 1'b1, 0), 1'b1);
        send(32'h7F000000, mk(32'h00000000, 1'b0, 1'b0, 0), 1'b1);
        send(32'h7E800000, mk(32'h00800000, 1'b0, 1'b0, 0), 1'b1);
        drain();

        // Backpressure: result held with out_ready low, released on the sixth cycle
        out_ready = 1'b0;
        send(32'h40800000, mk(32'h3E800000, 1'b0, 1'b0, 0), 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'h3E800000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Reset while the operation is in MUL_B: nothing may come out
        send(32'h40400000, mk(32'h0, 1'b0, 1'b0, 0), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        low_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) low_seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_valid", 32'(low_seen), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        send(32'h3F800000, mk(32'h3F800000, 1'b0, 1'b0, 0), 1'b1);
        drain();

        // Randomised operands against the division model, with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0: d = sp[$urandom_range(0, 5)];
                1: d = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'd0};
                2: d = {1'($urandom_range(0, 1)), 8'($urandom_range(250, 254)), 23'($urandom)};
                default: d = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            endcase
            send(d, model(d), 1'b1);
        end
        drain();
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1);
    end

endmodule
